// File: rtl/serdesphy_pcs_tx_path_pkg.sv
// serdesphy_pcs_tx_path_pkg: shared state encodings, LFSR seed and PRBS step function for the PCS TX path
package serdesphy_pcs_tx_path_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2,
        ST_PRBS = 2'd3
    } tx_state_e;

    localparam int          LFSR_W    = 15;
    localparam int          PRBS7_HI  = 6;
    localparam int          PRBS7_LO  = 5;
    localparam int          PRBS15_HI = 14;
    localparam int          PRBS15_LO = 13;
    localparam logic [14:0] LFSR_SEED = '1;

    // One Fibonacci step. PRBS7 lives in the low 7 bits; the upper bits just
    // shift along unused, so a single 15-bit register serves both modes.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s, input logic mode);
        return {s[LFSR_W-2:0], mode ? s[PRBS15_HI] ^ s[PRBS15_LO] : s[PRBS7_HI] ^ s[PRBS7_LO]};
    endfunction

endpackage

// File: rtl/serdesphy_pcs_tx_path_fifo.sv
// serdesphy_pcs_tx_path_fifo: single-clock word FIFO with synchronous flush
//  clk, rst_n : clock, async active-low reset
//  flush      : empties the FIFO at the next edge (wins over push/pop)
//  push/wdata : write request; ignored while full, even with a same-cycle pop
//  pop/rdata  : read request; rdata shows the head word combinationally
//  full/empty/level : occupancy status, level saturates at DEPTH
module serdesphy_pcs_tx_path_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/serdesphy_pcs_tx_path.sv
// serdesphy_pcs_tx_path: PCS TX datapath - word FIFO, PRBS7/15 generator, idle insertion, MSB-first serializer
//  clk_240m_tx, rst_n_240m_tx : TX clock, async active-low reset
//  tx_en, tx_fifo_en, tx_prbs_en, tx_idle, tx_data_sel, prbs_mode, clr_sticky : control
//  tx_data, tx_valid          : parallel word write port into the FIFO
//  tx_serial_data/valid       : registered serial bit stream to the PMA
//  tx_idle_pattern            : bit on the wire belongs to IDLE_WORD
//  tx_fifo_full/empty/level   : FIFO status
//  tx_overflow, tx_underflow, tx_error : sticky error flags
//  tx_active                  : sending DATA or PRBS
module serdesphy_pcs_tx_path
    import serdesphy_pcs_tx_path_pkg::*;
#(
    parameter int                DATA_W     = 4,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD  = {DATA_W/2{2'b10}}
) (
    input  logic                          clk_240m_tx,
    input  logic                          rst_n_240m_tx,
    input  logic                          tx_en,
    input  logic                          tx_fifo_en,
    input  logic                          tx_prbs_en,
    input  logic                          tx_idle,
    input  logic                          tx_data_sel,
    input  logic                          prbs_mode,
    input  logic                          clr_sticky,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_serial_data,
    output logic                          tx_serial_valid,
    output logic                          tx_idle_pattern,
    output logic                          tx_fifo_full,
    output logic                          tx_fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_level,
    output logic                          tx_overflow,
    output logic                          tx_underflow,
    output logic                          tx_active,
    output logic                          tx_error
);

    localparam int CW = $clog2(DATA_W);

    tx_state_e         state;
    tx_state_e         state_nxt;
    tx_state_e         sel;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0] word;
    logic [LFSR_W-1:0] lfsr;
    logic              prbs_sel;
    logic              word_idle;
    logic              boundary;
    logic              fifo_pop;
    logic              use_fifo;
    logic              prbs_entry;
    logic              prbs_bit;

    serdesphy_pcs_tx_path_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_240m_tx),
        .rst_n (rst_n_240m_tx),
        .flush (~tx_fifo_en),
        .push  (tx_valid & tx_fifo_en),
        .pop   (fifo_pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (tx_fifo_full),
        .empty (tx_fifo_empty),
        .level (tx_fifo_level)
    );

    assign boundary   = tx_en & (bit_cnt == '0);
    assign fifo_pop   = boundary & (sel == ST_DATA);
    assign use_fifo   = fifo_pop & ~tx_fifo_empty;
    assign word       = use_fifo ? fifo_rdata : IDLE_WORD;
    assign prbs_entry = boundary & (sel == ST_PRBS) & (state != ST_PRBS);
    assign prbs_bit   = prbs_sel ? lfsr[PRBS15_HI] : lfsr[PRBS7_HI];
    assign tx_active  = (state == ST_DATA) | (state == ST_PRBS);
    assign tx_error   = tx_overflow | tx_underflow;

    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx)
            state <= ST_OFF;
        else
            state <= state_nxt;
    end

    // Source is only re-evaluated at word boundaries; dropping tx_en aborts at once.
    always_comb begin
        sel       = tx_idle ? ST_IDLE : tx_data_sel ? (tx_prbs_en ? ST_PRBS : ST_IDLE) : ST_DATA;
        state_nxt = !tx_en ? ST_OFF : boundary ? sel : state;
    end

    // Output register lags the shift register by one cycle: the bit emitted at
    // a boundary edge is still the last bit of the outgoing word, so valid and
    // idle_pattern are derived from the pre-edge state/word to stay aligned.
    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            bit_cnt         <= '0;
            shift           <= '0;
            word_idle       <= 1'b0;
            lfsr            <= LFSR_SEED;
            prbs_sel        <= 1'b0;
            tx_serial_data  <= 1'b0;
            tx_serial_valid <= 1'b0;
            tx_idle_pattern <= 1'b0;
        end else if (!tx_en) begin
            bit_cnt         <= '0;
            shift           <= '0;
            word_idle       <= 1'b0;
            tx_serial_data  <= 1'b0;
            tx_serial_valid <= 1'b0;
            tx_idle_pattern <= 1'b0;
        end else begin
            bit_cnt         <= (bit_cnt == CW'(DATA_W-1)) ? '0 : bit_cnt + 1'b1;
            shift           <= boundary ? word : shift << 1;
            word_idle       <= boundary ? (sel != ST_PRBS) & ~use_fifo : word_idle;
            lfsr            <= prbs_entry ? LFSR_SEED : (state == ST_PRBS) ? lfsr_step(lfsr, prbs_sel) : lfsr;
            prbs_sel        <= prbs_entry ? prbs_mode : prbs_sel;
            tx_serial_data  <= (state == ST_PRBS) ? prbs_bit : shift[DATA_W-1];
            tx_serial_valid <= state != ST_OFF;
            tx_idle_pattern <= (state != ST_OFF) & word_idle;
        end
    end

    // A new set event in the same cycle as clr_sticky keeps the flag set.
    always_ff @(posedge clk_240m_tx or negedge rst_n_240m_tx) begin
        if (!rst_n_240m_tx) begin
            tx_overflow  <= 1'b0;
            tx_underflow <= 1'b0;
        end else begin
            tx_overflow  <= (tx_valid & tx_fifo_full) | (tx_overflow & ~clr_sticky);
            tx_underflow <= (fifo_pop & tx_fifo_empty) | (tx_underflow & ~clr_sticky);
        end
    end

endmodule

// File: tb/tb_serdesphy_pcs_tx_path.sv
// tb_serdesphy_pcs_tx_path: directed self-checking bench for serdesphy_pcs_tx_path (DATA_W=4, FIFO_DEPTH=8)
module tb_serdesphy_pcs_tx_path;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       tx_fifo_en = 1'b0;
    logic       tx_prbs_en = 1'b0;
    logic       tx_idle = 1'b0;
    logic       tx_data_sel = 1'b0;
    logic       prbs_mode = 1'b0;
    logic       clr_sticky = 1'b0;
    logic [3:0] tx_data = 4'h0;
    logic       tx_valid = 1'b0;
    logic       tx_serial_data;
    logic       tx_serial_valid;
    logic       tx_idle_pattern;
    logic       tx_fifo_full;
    logic       tx_fifo_empty;
    logic [3:0] tx_fifo_level;
    logic       tx_overflow;
    logic       tx_underflow;
    logic       tx_active;
    logic       tx_error;
    logic [12:0] obs;

    int checks = 0;
    int errors = 0;

    serdesphy_pcs_tx_path #(
        .DATA_W     (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_240m_tx     (clk),
        .rst_n_240m_tx   (rst_n),
        .tx_en           (tx_en),
        .tx_fifo_en      (tx_fifo_en),
        .tx_prbs_en      (tx_prbs_en),
        .tx_idle         (tx_idle),
        .tx_data_sel     (tx_data_sel),
        .prbs_mode       (prbs_mode),
        .clr_sticky      (clr_sticky),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_serial_data  (tx_serial_data),
        .tx_serial_valid (tx_serial_valid),
        .tx_idle_pattern (tx_idle_pattern),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_empty   (tx_fifo_empty),
        .tx_fifo_level   (tx_fifo_level),
        .tx_overflow     (tx_overflow),
        .tx_underflow    (tx_underflow),
        .tx_active       (tx_active),
        .tx_error        (tx_error)
    );

    // {ser, valid, idle_pat, full, empty, ovf, unf, active, error, level[3:0]}; idle/reset value is 13'h100
    assign obs = {tx_serial_data, tx_serial_valid, tx_idle_pattern, tx_fifo_full, tx_fifo_empty,
                  tx_overflow, tx_underflow, tx_active, tx_error, tx_fifo_level};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++;
        if (obs !== 13'h100) begin errors++; $display("FAIL reset_obs got %h exp %h", obs, 13'h100); end
        rst_n = 1'b1;
        tx_fifo_en = 1'b1;
        tick;
        checks++;
        if (obs !== 13'h100) begin errors++; $display("FAIL reset_release_obs got %h exp %h", obs, 13'h100); end
    endtask

    task automatic test_idle;
        logic [7:0] bits;
        logic [7:0] ipv;
        logic [7:0] act;
        tx_idle = 1'b1;
        tx_en = 1'b1;
        tick;
        checks++;
        if (tx_serial_valid !== 1'b0) begin errors++; $display("FAIL idle_first_valid got %b exp 0", tx_serial_valid); end
        for (int i = 0; i < 8; i++) begin
            tick;
            bits = {bits[6:0], tx_serial_data};
            ipv  = {ipv[6:0], tx_idle_pattern};
            act  = {act[6:0], tx_active};
        end
        checks++;
        if (bits !== 8'b1010_1010) begin errors++; $display("FAIL idle_bits got %b exp 10101010", bits); end
        checks++;
        if (ipv !== 8'hFF || act !== 8'h00) begin errors++; $display("FAIL idle_flags got ip=%b act=%b exp ip=11111111 act=00000000", ipv, act); end
        tx_en = 1'b0;
        tx_idle = 1'b0;
        tick;
        checks++;
        if (obs !== 13'h100) begin errors++; $display("FAIL idle_off_obs got %h exp %h", obs, 13'h100); end
    endtask

    task automatic test_data;
        logic [7:0] bits;
        logic [7:0] ipv;
        tx_data = 4'hA;
        tx_valid = 1'b1;
        tick;
        tx_data = 4'h3;
        tick;
        tx_valid = 1'b0;
        checks++;
        if (tx_fifo_level !== 4'd2) begin errors++; $display("FAIL data_level got %0d exp 2", tx_fifo_level); end
        tx_data_sel = 1'b0;
        tx_en = 1'b1;
        tick;
        checks++;
        if (tx_serial_valid !== 1'b0 || tx_active !== 1'b1 || tx_fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL data_entry got valid=%b active=%b level=%0d exp valid=0 active=1 level=1", tx_serial_valid, tx_active, tx_fifo_level);
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            bits = {bits[6:0], tx_serial_data};
            ipv  = {ipv[6:0], tx_idle_pattern};
        end
        checks++;
        if (bits !== 8'b1010_0011) begin errors++; $display("FAIL data_bits got %b exp 10100011", bits); end
        checks++;
        if (ipv !== 8'h00) begin errors++; $display("FAIL data_idle_pat got %b exp 00000000", ipv); end
        tick;
        checks++;
        if (tx_serial_data !== 1'b1 || tx_idle_pattern !== 1'b1 || tx_underflow !== 1'b1 || tx_error !== 1'b1) begin
            errors++;
            $display("FAIL data_underflow got ser=%b ip=%b unf=%b err=%b exp 1 1 1 1", tx_serial_data, tx_idle_pattern, tx_underflow, tx_error);
        end
        tx_en = 1'b0;
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
        checks++;
        if (obs !== 13'h100) begin errors++; $display("FAIL data_clear_obs got %h exp %h", obs, 13'h100); end
    endtask

    task automatic test_overflow;
        logic [35:0] bits;
        for (int i = 0; i < 8; i++) begin
            tx_data = 4'(i);
            tx_valid = 1'b1;
            tick;
        end
        checks++;
        if (tx_fifo_full !== 1'b1 || tx_fifo_level !== 4'd8 || tx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got full=%b level=%0d ovf=%b exp 1 8 0", tx_fifo_full, tx_fifo_level, tx_overflow);
        end
        tx_data = 4'hF;
        tick;
        checks++;
        if (tx_overflow !== 1'b1 || tx_error !== 1'b1 || tx_fifo_level !== 4'd8) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b err=%b level=%0d exp 1 1 8", tx_overflow, tx_error, tx_fifo_level);
        end
        clr_sticky = 1'b1;
        tick;
        checks++;
        if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", tx_overflow); end
        tx_valid = 1'b0;
        tick;
        clr_sticky = 1'b0;
        checks++;
        if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", tx_overflow); end
        tx_en = 1'b1;
        tick;
        for (int i = 0; i < 36; i++) begin
            tick;
            bits = {bits[34:0], tx_serial_data};
        end
        checks++;
        if (bits !== 36'h0_1234_567A) begin errors++; $display("FAIL ovf_drain_bits got %h exp 01234567a", bits); end
        checks++;
        if (tx_underflow !== 1'b1 || tx_fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain_flags got unf=%b empty=%b exp 1 1", tx_underflow, tx_fifo_empty);
        end
        tx_en = 1'b0;
        tx_data = 4'h5;
        tx_valid = 1'b1;
        tick;
        tick;
        tx_valid = 1'b0;
        tx_fifo_en = 1'b0;
        tick;
        checks++;
        if (tx_fifo_empty !== 1'b1 || tx_fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL flush got empty=%b level=%0d exp 1 0", tx_fifo_empty, tx_fifo_level);
        end
        tx_valid = 1'b1;
        tick;
        checks++;
        if (tx_fifo_level !== 4'd0) begin errors++; $display("FAIL flush_blocks_push got level=%0d exp 0", tx_fifo_level); end
        tx_valid = 1'b0;
        tx_fifo_en = 1'b1;
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
    endtask

    task automatic test_prbs7;
        logic [6:0]   m;
        logic [126:0] s1;
        logic [126:0] s2;
        int           bad;
        m = 7'h7F;
        bad = 0;
        tx_data_sel = 1'b1;
        tx_prbs_en = 1'b1;
        prbs_mode = 1'b0;
        tx_en = 1'b1;
        tick;
        prbs_mode = 1'b1;
        for (int i = 0; i < 254; i++) begin
            tick;
            if (tx_serial_data !== m[6] || tx_serial_valid !== 1'b1 || tx_active !== 1'b1) bad++;
            if (i < 127) s1 = {s1[125:0], tx_serial_data};
            else s2 = {s2[125:0], tx_serial_data};
            m = {m[5:0], m[6] ^ m[5]};
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL prbs7_seq got %0d bad bits exp 0", bad); end
        checks++;
        if ($countones(s1) !== 64) begin errors++; $display("FAIL prbs7_ones got %0d exp 64", $countones(s1)); end
        checks++;
        if (s1 !== s2) begin errors++; $display("FAIL prbs7_period got %h exp %h", s2, s1); end
        prbs_mode = 1'b0;
    endtask

    task automatic test_reset_mid_prbs;
        logic [6:0] m;
        int         bad;
        m = 7'h7F;
        bad = 0;
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h100) begin errors++; $display("FAIL midreset_async_obs got %h exp %h", obs, 13'h100); end
        tick;
        checks++;
        if (obs !== 13'h100) begin errors++; $display("FAIL midreset_edge_obs got %h exp %h", obs, 13'h100); end
        rst_n = 1'b1;
        tick;
        checks++;
        if (tx_serial_valid !== 1'b0 || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL midreset_entry got valid=%b active=%b exp 0 1", tx_serial_valid, tx_active);
        end
        for (int i = 0; i < 12; i++) begin
            tick;
            if (tx_serial_data !== m[6]) bad++;
            m = {m[5:0], m[6] ^ m[5]};
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL midreset_seed got %0d bad bits exp 0", bad); end
    endtask

    task automatic test_switch;
        logic [7:0] bits;
        logic [7:0] ipv;
        tx_en = 1'b0;
        tx_data_sel = 1'b0;
        tick;
        tx_en = 1'b1;
        tick;
        tx_data_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            bits = {bits[6:0], tx_serial_data};
            ipv  = {ipv[6:0], tx_idle_pattern};
        end
        checks++;
        if (bits !== 8'b1010_1111) begin errors++; $display("FAIL switch_bits got %b exp 10101111", bits); end
        checks++;
        if (ipv !== 8'b1111_0000) begin errors++; $display("FAIL switch_idle_pat got %b exp 11110000", ipv); end
        tx_en = 1'b0;
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
    endtask

    task automatic test_prbs15;
        logic [14:0] m;
        logic [31:0] head;
        logic [31:0] tail;
        int          bad;
        int          ones;
        m = 15'h7FFF;
        bad = 0;
        ones = 0;
        prbs_mode = 1'b1;
        tx_en = 1'b1;
        tick;
        for (int i = 0; i < 32767 + 32; i++) begin
            tick;
            if (tx_serial_data !== m[14] || tx_serial_valid !== 1'b1) bad++;
            if (i < 32) head = {head[30:0], tx_serial_data};
            if (i < 32767 && tx_serial_data === 1'b1) ones++;
            if (i >= 32767) tail = {tail[30:0], tx_serial_data};
            m = {m[13:0], m[14] ^ m[13]};
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL prbs15_seq got %0d bad bits exp 0", bad); end
        checks++;
        if (ones !== 16384) begin errors++; $display("FAIL prbs15_ones got %0d exp 16384", ones); end
        checks++;
        if (tail !== head) begin errors++; $display("FAIL prbs15_period got %h exp %h", tail, head); end
        tx_en = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_idle;
        test_data;
        test_overflow;
        test_prbs7;
        test_reset_mid_prbs;
        test_switch;
        test_prbs15;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
